// File: rtl/alu_op_sequencer.sv
// Byte-bus operand/opcode collector that issues one ALU op and waits, bounded by TIMEOUT, for its result.
// Issue-to-done latency is at least 2 cycles; strobe rises outside IDLE/GOT_A are dropped, and abort returns to IDLE.
module alu_op_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic [2:0] opcode_in,
    input  logic       strobe,
    input  logic       abort,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    output logic       alu_start,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_valid,
    output logic [7:0] result,
    output logic       carry,
    output logic       zero,
    output logic       err,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GOT_A,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       strobe_q, strobe_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic [7:0] result_q, result_d;
    logic       carry_q, carry_d;
    logic       zero_q, zero_d;
    logic       err_q, err_d;
    logic       start_q, start_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       rise;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        strobe_d = strobe;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        err_d    = err_q;
        rise     = strobe & ~strobe_q;

        // Abort outranks every other event, including a rise seen in IDLE.
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        alu_a_d  = data_in;
                        alu_op_d = opcode_in;
                        if (opcode_in[2]) begin
                            alu_b_d = 8'h00;
                            state_d = S_ISSUE;
                        end else begin
                            state_d = S_GOT_A;
                        end
                    end
                end
                S_GOT_A: begin
                    if (rise) begin
                        alu_b_d = data_in;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_d   = 8'h00;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (alu_valid) begin
                        result_d = alu_result;
                        carry_d  = alu_carry;
                        zero_d   = (alu_result == 8'h00);
                        err_d    = 1'b0;
                        state_d  = S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        result_d = 8'h00;
                        carry_d  = 1'b0;
                        zero_d   = 1'b0;
                        err_d    = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Pulses and busy are registered from the next state so they line up with it.
        start_d = (state_d == S_ISSUE);
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'h00;
            strobe_q <= 1'b1;
            alu_a_q  <= 8'h00;
            alu_b_q  <= 8'h00;
            alu_op_q <= 3'd0;
            result_q <= 8'h00;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            start_q  <= start_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_start = start_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU with programmable response delay plus directed and random ops.
// Expected results, flags and issue-to-done latency come from transaction-level arithmetic on the bench's own operands.
module tb_alu_op_sequencer;
    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic [2:0] opcode_in = 3'd0;
    logic       strobe = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] alu_a, alu_b, result;
    logic [2:0] alu_op;
    logic       alu_start, carry, zero, err, busy, done;
    logic [7:0] alu_result = 8'h00;
    logic       alu_carry = 1'b0;
    logic       alu_valid;
    logic       vld_model = 1'b0;
    logic       vld_extra = 1'b0;

    int checks = 0, failures = 0;
    int cyc = 0, start_cnt = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0;
    int alu_lat = 0, rem = 0;

    assign alu_valid = vld_model | vld_extra;

    alu_op_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .opcode_in(opcode_in),
        .strobe(strobe), .abort(abort), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_start(alu_start), .alu_result(alu_result),
        .alu_carry(alu_carry), .alu_valid(alu_valid), .result(result),
        .carry(carry), .zero(zero), .err(err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: {carry, result}.
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {(a < b), 8'(a - b)};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, ~a};
            3'd5:    return {a[7], a[6:0], 1'b0};
            3'd6:    return {a[0], 1'b0, a[7:1]};
            default: return {1'b0, a} + 9'd1;
        endcase
    endfunction

    // Pulse monitor and ALU responder: valid is raised alu_lat cycles after the start cycle (0 = never).
    always @(negedge clk) begin
        logic [8:0] r;
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (alu_start) begin
            start_cnt++;
            start_cyc  = cyc;
            r          = alu_fn(alu_a, alu_b, alu_op);
            alu_result = r[7:0];
            alu_carry  = r[8];
            rem        = alu_lat;
            vld_model  = 1'b0;
        end else if (rem > 0) begin
            rem--;
            vld_model = (rem == 0);
        end else begin
            vld_model = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stb(input logic [7:0] d, input logic [2:0] op);
        data_in   = d;
        opcode_in = op;
        strobe    = 1'b1;
        tick();
        strobe    = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input int lat);
        int         s0, d0, exp_latency;
        logic [8:0] expv;
        logic       exp_err;
        logic [7:0] eb;
        s0          = start_cnt;
        d0          = done_cnt;
        eb          = op[2] ? 8'h00 : b;
        alu_lat     = lat;
        exp_err     = (lat < 1 || lat > TIMEOUT);
        expv        = exp_err ? 9'h000 : alu_fn(a, eb, op);
        exp_latency = exp_err ? TIMEOUT + 1 : lat + 1;
        stb(a, op);
        if (op[2]) begin
            chk("unary_start_next", alu_start, 1);
        end else begin
            chk("got_a_busy", busy, 1);
            chk("got_a_no_start", alu_start, 0);
            tick();
            stb(b, ~op);
            chk("binary_start", alu_start, 1);
        end
        wait_done(d0);
        chk("start_pulses", 32'(start_cnt - s0), 1);
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, eb);
        chk("alu_op", alu_op, op);
        chk("result", result, expv[7:0]);
        chk("carry", carry, expv[8]);
        chk("zero", zero, (!exp_err && expv[7:0] == 8'h00));
        chk("err", err, exp_err);
        chk("latency", 32'(done_cyc - start_cyc), 32'(exp_latency));
        chk("busy_at_done", busy, 1);
        tick();
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        int d0, s0, r;
        // Reset state, with strobe held high across reset release.
        data_in = 8'h11;
        strobe  = 1'b1;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_start", alu_start, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {carry, zero, err}, 0);
        chk("rst_operands", {alu_a, alu_b, alu_op}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) tick();
        chk("held_strobe_no_capture", busy, 0);
        chk("held_strobe_alu_a", alu_a, 0);
        strobe = 1'b0;
        tick();

        // Directed ops: binary add with carry-out to zero, unary invert, timeout, then a good op clearing err.
        do_op(8'h3C, 8'hC4, 3'd0, 2);
        do_op(8'h81, 8'h55, 3'd4, 2);
        do_op(8'h12, 8'h34, 3'd1, 0);
        do_op(8'h2D, 8'h2D, 3'd0, 1);
        do_op(8'h90, 8'h0F, 3'd3, TIMEOUT);
        do_op(8'h2D, 8'h2D, 3'd0, 1);

        // Strobe held for 5 cycles in IDLE captures only A; abort from GOT_A.
        d0        = done_cnt;
        data_in   = 8'h77;
        opcode_in = 3'd0;
        strobe    = 1'b1;
        tick();
        data_in   = 8'h99;
        repeat (4) tick();
        chk("hold_busy", busy, 1);
        chk("hold_alu_a", alu_a, 8'h77);
        chk("hold_alu_b", alu_b, 8'h2D);
        chk("hold_no_start", alu_start, 0);
        strobe = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_got_a_idle", busy, 0);
        tick();
        chk("abort_got_a_no_done", 32'(done_cnt - d0), 0);
        chk("abort_got_a_result", result, 8'h5A);

        // Abort in WAIT coincident with alu_valid.
        alu_lat = 0;
        stb(8'h10, 3'd0);
        tick();
        stb(8'h20, 3'd0);
        tick();
        tick();
        abort     = 1'b1;
        vld_extra = 1'b1;
        tick();
        abort     = 1'b0;
        vld_extra = 1'b0;
        chk("abort_wait_idle", busy, 0);
        repeat (3) tick();
        chk("abort_wait_no_done", 32'(done_cnt - d0), 0);
        chk("abort_wait_result", result, 8'h5A);
        chk("abort_wait_flags", {carry, zero, err}, 0);

        // Abort in IDLE suppresses a coincident rise.
        abort = 1'b1;
        stb(8'h42, 3'd0);
        abort = 1'b0;
        chk("abort_idle_no_capture", busy, 0);
        chk("abort_idle_alu_a", alu_a, 8'h10);
        tick();
        do_op(8'hA5, 8'h5B, 3'd3, 3);

        // Asynchronous reset in WAIT with the ALU response still pending.
        s0      = start_cnt;
        d0      = done_cnt;
        alu_lat = 5;
        stb(8'h33, 3'd0);
        tick();
        stb(8'h44, 3'd0);
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_start", alu_start, 0);
        chk("arst_result", result, 0);
        chk("arst_err", err, 0);
        chk("arst_alu_a", alu_a, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("late_valid_busy", busy, 0);
        chk("late_valid_no_done", 32'(done_cnt - d0), 0);
        chk("late_valid_result", result, 0);
        chk("arst_single_start", 32'(start_cnt - s0), 1);

        // Random ops, including timeouts and valid on the final WAIT cycle.
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            do_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                  (r == 0) ? 0 : (r == 1) ? $urandom_range(TIMEOUT + 1, TIMEOUT + 4)
                                          : $urandom_range(1, TIMEOUT));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequencing controller in front of the 8-bit ALU. It collects operands and an opcode from a shared 8-bit byte bus using strobe edges, issues one start pulse to the ALU, and waits for the ALU's result with a bounded timeout. It then presents the latched result, carry, zero and error flags to the top-level output mux. It sits between the pad-level inputs (`ui_in`/`uio_in`) and the ALU datapath in the top-level wrapper.

## Interface
Parameters:
- `TIMEOUT` (default 15): maximum number of WAIT cycles without `alu_valid` before an error is flagged. Legal range is 1–255.

Ports:
- `clk`  in  1  single design clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  8  operand byte bus.
- `opcode_in`  in  3  opcode; sampled together with operand A.
- `strobe`  in  1  byte-valid; only its rising edge is acted on.
- `abort`  in  1  synchronous abort; returns the block to IDLE.
- `alu_a`  out  8  operand A to the ALU.
- `alu_b`  out  8  operand B to the ALU.
- `alu_op`  out  3  opcode to the ALU.
- `alu_start`  out  1  one-cycle issue pulse to the ALU.
- `alu_result`  in  8  ALU result.
- `alu_carry`  in  1  ALU carry.
- `alu_valid`  in  1  ALU result qualifier.
- `result`  out  8  latched result.
- `carry`  out  1  latched carry.
- `zero`  out  1  high when `result` == 0 after a valid completion.
- `err`  out  1  high when the last operation timed out.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Strobe edge detect:
  - `strobe_q` is registered every cycle and resets to 1.
  - A rise is `strobe & ~strobe_q`.
  - A strobe held high through reset release does not count as a rise.
- States: IDLE, GOT_A, ISSUE, WAIT, DONE. Encoding is free.
- IDLE:
  - On a rise: `alu_a` <= `data_in`, `alu_op` <= `opcode_in`.
  - If `opcode_in[2]`=1 (unary op): `alu_b` <= 0 and go to ISSUE.
  - Otherwise go to GOT_A.
- GOT_A: on a rise, `alu_b` <= `data_in` and go to ISSUE. `opcode_in` is ignored in this state.
- ISSUE:
  - `alu_start`=1 for exactly this one cycle.
  - Clear the timeout counter and go to WAIT.
  - `alu_valid` is ignored in this state.
- WAIT:
  - If `alu_valid`: `result` <= `alu_result`, `carry` <= `alu_carry`, `zero` <= (`alu_result` == 0), `err` <= 0; go to DONE.
  - Else, if the counter == TIMEOUT-1: `result` <= 0, `carry` <= 0, `zero` <= 0, `err` <= 1; go to DONE.
  - Else increment the counter.
- DONE: `done`=1 for this cycle only; go to IDLE.
- Strobe rises outside IDLE/GOT_A are ignored and dropped; they are not queued.
- Abort:
  - In any non-IDLE state, `abort`=1 forces IDLE at the next edge.
  - No `done` pulse is generated.
  - `result`/`carry`/`zero`/`err` are left unchanged.
  - Abort has priority over strobe, `alu_valid` and timeout in the same cycle.
  - In IDLE, abort also suppresses capture of a coincident rise.
- `result`, `carry`, `zero` and `err` hold their values until the next DONE or a reset.
- Operand registers `alu_a`/`alu_b`/`alu_op` hold their values after DONE until the next capture.

## Timing
- Reset values (asserted asynchronously): state=IDLE, all outputs 0, counter=0, `strobe_q`=1.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Binary op: rise A sampled at edge N, rise B at edge M (M ≥ N+1).
  - `alu_start` is high during cycle M..M+1.
  - If `alu_valid` is sampled high at edge K ≥ M+2: `result` and flags update at edge K and `done` is high in cycle K..K+1.
  - `busy` falls at edge K+1.
- Unary op: `alu_start` is high in the cycle directly after the A-capture edge.
- Minimum issue-to-done latency is 2 cycles, i.e. an ALU with valid in the first WAIT cycle.
- Timeout: with no valid, `err` and `done` assert after exactly TIMEOUT WAIT cycles. With TIMEOUT=15, `done` occurs 16 cycles after the `alu_start` cycle.
- `alu_valid` and timeout in the same cycle: valid wins, and `err`=0.
- A new rise is accepted in the cycle after DONE, i.e. the first IDLE cycle.
- Reset mid-operation: state and outputs clear immediately. No `done` pulse and no `alu_start` are produced.

## Test plan
- **Binary add:** ALU model returns A+B with valid 2 cycles after start. Strobe A=0x3C (op=0), then B=0xC4.
  - Required: one `alu_start` pulse, `alu_a`=0x3C, `alu_b`=0xC4, `result`=0x00, `carry`=1, `zero`=1, `err`=0.
  - Required: one `done` pulse 3 cycles after the start cycle; `busy` high from the A capture until after DONE.
- **Unary op:** strobe A=0x81 with op=4.
  - Required: `alu_start` in the next cycle, `alu_b`=0, no wait for a second strobe.
  - Required: model result 0x7E is latched, `zero`=0.
- **Timeout:** ALU model never asserts valid, TIMEOUT=15.
  - Required: `done` and `err`=1 exactly 16 cycles after `alu_start`, `result`=0.
  - Required: a following good op clears `err` to 0.
- **Strobe hygiene:** strobe held high for 5 cycles in IDLE → only A is captured; the block stays in GOT_A. Strobe held high across reset release → no capture.
- **Abort:** assert `abort` in GOT_A, then separately in WAIT, with `alu_valid` coincident.
  - Required: return to IDLE, no `done` pulse, `result` keeps its previous value (0x5A).
  - Required: a subsequent full op completes normally.
- **Async reset mid-WAIT:** assert `rst` between clock edges.
  - Required: `busy`, `alu_start`, `result` and `err` go to 0 immediately, without waiting for a clock edge.
  - Required: a late `alu_valid` after reset release is ignored.
